// File: rtl/random_pkg.sv
// ---------------------------------------------------------------------------
// random_pkg
// Shared constants and types for the random_arbiter slice:
//   RNG_WIDTH       - width of the random source and of every result (8)
//   LFSR_TAPS       - feedback mask, taps on bits 7,5,4,3
//   LFSR_ZERO_SEED  - value loaded instead of an all-zero seed (the LFSR
//                     would otherwise lock up at zero)
//   state_t / ST_*  - arbiter FSM encoding
//   lfsr_next()     - one LFSR step
// ---------------------------------------------------------------------------
package random_pkg;

    localparam int         RNG_WIDTH      = 8;
    localparam logic [7:0] LFSR_TAPS      = 8'hB8;
    localparam logic [7:0] LFSR_ZERO_SEED = 8'h01;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_ARB  = 3'd1;
    localparam state_t ST_STEP = 3'd2;
    localparam state_t ST_MAP  = 3'd3;
    localparam state_t ST_RESP = 3'd4;

    // Shift left, new LSB is the XOR of the tapped bits.
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lfsr8_core.sv
// ---------------------------------------------------------------------------
// lfsr8_core
// 8-bit Fibonacci LFSR that only moves when asked to.
// Ports:
//   clock - rising-edge clock
//   reset - asynchronous, active-high; loads seed (LFSR_ZERO_SEED if seed==0)
//   seed  - reload value, only looked at while reset is high
//   step  - advance the LFSR by one on the next rising edge
//   value - current LFSR contents
// ---------------------------------------------------------------------------
module lfsr8_core
    import random_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic [RNG_WIDTH-1:0] seed,
    input  logic                 step,
    output logic [RNG_WIDTH-1:0] value
);

    logic [RNG_WIDTH-1:0] value_q;
    logic [RNG_WIDTH-1:0] value_d;
    logic [RNG_WIDTH-1:0] seed_eff;

    assign seed_eff = (seed == '0) ? LFSR_ZERO_SEED : seed;

    always_comb begin
        value_d = value_q;
        if (step) begin
            value_d = lfsr_next(value_q);
        end
    end

    // Reset loads a port value rather than a constant, so the register
    // tracks in_seed for as long as reset is held.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            value_q <= seed_eff;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/random_arbiter.sv
// ---------------------------------------------------------------------------
// random_arbiter
// Round-robin arbiter in front of one shared 8-bit LFSR. Each serviced
// requester receives a signed value drawn from its own inclusive range
// [min,max]. One transaction walks IDLE->ARB->STEP->MAP->RESP, one cycle each.
//
// Handshake: a requester holds its in_req bit high until it sees its bit of
// out_grant together with out_valid (a single-cycle strobe); out_random,
// out_owner and out_error belong to that strobe and random/owner are held
// until the next one.
//
// Ports:
//   in_clock, in_reset   clock; asynchronous active-high reset
//   in_seed              LFSR seed, sampled while in_reset=1
//   in_req               request level per requester
//   in_min / in_max      packed signed 8-bit range bounds, slot i at [8i+7:8i]
//   out_grant            one-hot grant, valid with out_valid
//   out_valid            result strobe
//   out_random           signed result
//   out_owner            index of the serviced requester
//   out_error            serviced range had min>max (result is min)
//   out_dbg_state        current FSM state (ST_* in random_pkg)
//   out_serviced_count   RESP-cycle counter, only with RANDOM_ARBITER_STATS_EN
//
// Build option: define RANDOM_ARBITER_STATS_EN to add out_serviced_count.
// ---------------------------------------------------------------------------
module random_arbiter
    import random_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic                   in_clock,
    input  logic                   in_reset,
    input  logic [RNG_WIDTH-1:0]   in_seed,
    input  logic [NUM_REQ-1:0]     in_req,
    input  logic [NUM_REQ*8-1:0]   in_min,
    input  logic [NUM_REQ*8-1:0]   in_max,
    output logic [NUM_REQ-1:0]     out_grant,
    output logic                   out_valid,
    output logic [RNG_WIDTH-1:0]   out_random,
    output logic [IDX_W-1:0]       out_owner,
    output logic                   out_error,
    output logic [2:0]             out_dbg_state
`ifdef RANDOM_ARBITER_STATS_EN
    ,
    output logic [15:0]            out_serviced_count
`endif
);

    state_t               state_q;
    state_t               state_d;

    // Transaction latched in ARB
    logic [IDX_W-1:0]     owner_q;
    logic [7:0]           min_q;
    logic [7:0]           max_q;

    // Requester with highest priority in the next ARB
    logic [IDX_W-1:0]     ptr_q;

    // Registered outputs
    logic [NUM_REQ-1:0]   grant_q;
    logic                 valid_q;
    logic [7:0]           random_q;
    logic [IDX_W-1:0]     owner_out_q;
    logic                 error_q;

    logic [RNG_WIDTH-1:0] lfsr_value;

    // -----------------------------------------------------------------------
    // LFSR: advances only while the FSM sits in STEP
    // -----------------------------------------------------------------------
    lfsr8_core u_lfsr (
        .clock (in_clock),
        .reset (in_reset),
        .seed  (in_seed),
        .step  (state_q == ST_STEP),
        .value (lfsr_value)
    );

    // -----------------------------------------------------------------------
    // Round-robin search starting at ptr_q. cand is one bit wider than an
    // index so ptr_q+k cannot overflow before the wrap subtraction.
    // -----------------------------------------------------------------------
    logic [IDX_W:0]       cand;
    logic                 win_found;
    logic [IDX_W-1:0]     win_idx;
    logic [IDX_W-1:0]     ptr_next;

    always_comb begin
        cand      = '0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr_q} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_REQ)) begin
                cand = cand - (IDX_W+1)'(NUM_REQ);
            end
            if (!win_found && in_req[cand[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDX_W-1:0];
            end
        end
    end

    assign ptr_next = (win_idx == IDX_W'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;

    // -----------------------------------------------------------------------
    // Range mapping. span is 9-bit so [-128,127] yields 256; for an inverted
    // range the divisor is forced to 1 since the result is min anyway and a
    // zero divisor (max == min-1) must not reach the modulo.
    // -----------------------------------------------------------------------
    logic signed [8:0]    span_s;
    logic                 inverted;
    logic [8:0]           divisor;
    logic [7:0]           offset;
    logic [7:0]           map_result;

    assign span_s     = $signed({max_q[7], max_q}) - $signed({min_q[7], min_q}) + 9'sd1;
    assign inverted   = $signed(min_q) > $signed(max_q);
    assign divisor    = inverted ? 9'd1 : span_s;
    assign offset     = 8'({1'b0, lfsr_value} % divisor);
    assign map_result = inverted ? min_q : (min_q + offset);

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = (|in_req) ? ST_ARB : ST_IDLE;
            // A request withdrawn between IDLE and ARB leaves nothing to serve.
            ST_ARB:  state_d = win_found ? ST_STEP : ST_IDLE;
            ST_STEP: state_d = ST_MAP;
            ST_MAP:  state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= '0;
            min_q       <= '0;
            max_q       <= '0;
            ptr_q       <= '0;
            grant_q     <= '0;
            valid_q     <= 1'b0;
            random_q    <= '0;
            owner_out_q <= '0;
            error_q     <= 1'b0;
        end else begin
            state_q <= state_d;

            if (state_q == ST_ARB && win_found) begin
                owner_q <= win_idx;
                min_q   <= in_min[win_idx*8 +: 8];
                max_q   <= in_max[win_idx*8 +: 8];
                ptr_q   <= ptr_next;
            end

            // Strobes are loaded on the MAP->RESP edge so they are high
            // exactly for the RESP cycle.
            valid_q <= 1'b0;
            grant_q <= '0;
            error_q <= 1'b0;
            if (state_q == ST_MAP) begin
                valid_q     <= 1'b1;
                grant_q     <= {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q;
                error_q     <= inverted;
                random_q    <= map_result;
                owner_out_q <= owner_q;
            end
        end
    end

`ifdef RANDOM_ARBITER_STATS_EN
    logic [15:0] serviced_q;

    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            serviced_q <= '0;
        end else if (state_q == ST_RESP) begin
            serviced_q <= serviced_q + 16'd1;
        end
    end

    assign out_serviced_count = serviced_q;
`endif

    assign out_grant     = grant_q;
    assign out_valid     = valid_q;
    assign out_random    = random_q;
    assign out_owner     = owner_out_q;
    assign out_error     = error_q;
    assign out_dbg_state = state_q;

endmodule

// File: tb/tb_random_arbiter.sv
// ---------------------------------------------------------------------------
// tb_random_arbiter
// Self-checking bench for random_arbiter (NUM_REQ=4). The reference model
// tracks the last owner and the LFSR value and computes each result from the
// range rule with plain integer arithmetic. Inputs change on the falling
// edge; outputs are sampled on the falling edge.
// With RANDOM_ARBITER_STATS_EN defined, out_serviced_count is checked too.
// ---------------------------------------------------------------------------
module tb_random_arbiter;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;
    localparam int EXP_W   = NUM_REQ + IDX_W + 8 + 1;

    logic                 in_clock = 1'b0;
    logic                 in_reset = 1'b1;
    logic [7:0]           in_seed  = 8'h01;
    logic [NUM_REQ-1:0]   in_req   = '0;
    logic [NUM_REQ*8-1:0] in_min   = '0;
    logic [NUM_REQ*8-1:0] in_max   = '0;
    logic [NUM_REQ-1:0]   out_grant;
    logic                 out_valid;
    logic [7:0]           out_random;
    logic [IDX_W-1:0]     out_owner;
    logic                 out_error;
    logic [2:0]           out_dbg_state;
`ifdef RANDOM_ARBITER_STATS_EN
    logic [15:0]          out_serviced_count;
`endif

    random_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) dut (
        .in_clock      (in_clock),
        .in_reset      (in_reset),
        .in_seed       (in_seed),
        .in_req        (in_req),
        .in_min        (in_min),
        .in_max        (in_max),
        .out_grant     (out_grant),
        .out_valid     (out_valid),
        .out_random    (out_random),
        .out_owner     (out_owner),
        .out_error     (out_error),
        .out_dbg_state (out_dbg_state)
`ifdef RANDOM_ARBITER_STATS_EN
        ,
        .out_serviced_count (out_serviced_count)
`endif
    );

    // ---------------- clock ----------------
    always #5 in_clock = ~in_clock;

    // ---------------- scoreboard / model state ----------------
    int                checks   = 0;
    int                failures = 0;
    int                strobes  = 0;
    logic [EXP_W-1:0]  exp_q[$];
    logic [7:0]        m_lfsr;
    int                m_last;
    logic signed [7:0] slot_min [NUM_REQ];
    logic signed [7:0] slot_max [NUM_REQ];

    function automatic logic [7:0] m_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    function automatic int m_pick(input logic [NUM_REQ-1:0] pend, input int last);
        for (int k = 1; k <= NUM_REQ; k++) begin
            int c;
            c = (last + k) % NUM_REQ;
            if (pend[c]) return c;
        end
        return 0;
    endfunction

    task automatic model_reset(input logic [7:0] seed);
        m_lfsr  = (seed == 8'h00) ? 8'h01 : seed;
        m_last  = NUM_REQ - 1;
        strobes = 0;
        exp_q.delete();
    endtask

    // Pushes the expected {grant, owner, random, error} for the next service.
    task automatic predict(input logic [NUM_REQ-1:0] pend, output int w);
        int mn, mx, val;
        logic err;
        logic [NUM_REQ-1:0] g;
        logic [EXP_W-1:0] e;
        w      = m_pick(pend, m_last);
        m_last = w;
        m_lfsr = m_step(m_lfsr);
        mn = slot_min[w];
        mx = slot_max[w];
        if (mn > mx) begin
            val = mn;
            err = 1'b1;
        end else begin
            val = mn + (int'(m_lfsr) % (mx - mn + 1));
            err = 1'b0;
        end
        g    = '0;
        g[w] = 1'b1;
        e    = {g, IDX_W'(w), val[7:0], err};
        exp_q.push_back(e);
    endtask

    // ---------------- driver tasks ----------------
    task automatic apply_ranges();
        for (int i = 0; i < NUM_REQ; i++) begin
            in_min[8*i +: 8] = slot_min[i];
            in_max[8*i +: 8] = slot_max[i];
        end
    endtask

    task automatic do_reset(input logic [7:0] seed);
        @(negedge in_clock);
        in_reset = 1'b1;
        in_seed  = seed;
        in_req   = '0;
        repeat (2) @(negedge in_clock);
        in_reset = 1'b0;
        model_reset(seed);
    endtask

    // Returns the number of rising edges until out_valid is seen, -1 on timeout.
    task automatic wait_valid(input int budget, output int n);
        n = -1;
        for (int c = 1; c <= budget; c++) begin
            @(posedge in_clock);
            @(negedge in_clock);
            if (out_valid === 1'b1) begin
                n = c;
                strobes++;
                return;
            end
        end
    endtask

    function automatic logic [EXP_W-1:0] observed();
        return {out_grant, out_owner, out_random, out_error};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        in_reset = 1'b1;
        in_seed  = 8'h01;
        in_req   = '1;
        repeat (3) @(negedge in_clock);
        checks++; if (out_valid !== 1'b0)  begin failures++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++; if (out_grant !== '0)    begin failures++; $display("FAIL reset_grant: got %b want 0", out_grant); end
        checks++; if (out_random !== 8'h0) begin failures++; $display("FAIL reset_random: got %h want 00", out_random); end
        checks++; if (out_owner !== '0)    begin failures++; $display("FAIL reset_owner: got %0d want 0", out_owner); end
        checks++; if (out_error !== 1'b0)  begin failures++; $display("FAIL reset_error: got %b want 0", out_error); end
        in_req   = '0;
        in_reset = 1'b0;
        model_reset(8'h01);
    endtask

    task automatic test_single();
        int n, w;
        logic [EXP_W-1:0] e;
        do_reset(8'h01);
        slot_min[0] = 8'sd0; slot_max[0] = 8'sd9;
        apply_ranges();
        in_req = 4'b0001;
        predict(in_req, w);
        wait_valid(8, n);
        checks++; if (n !== 4) begin failures++; $display("FAIL single_latency: got %0d want 4", n); end
        e = exp_q.pop_front();
        checks++; if (observed() !== e) begin failures++; $display("FAIL single_result: got %h want %h", observed(), e); end
        checks++; if (out_random !== 8'd2) begin failures++; $display("FAIL single_value: got %0d want 2", $signed(out_random)); end
        in_req = '0;
        @(posedge in_clock);
        @(negedge in_clock);
        checks++;
        if (out_valid !== 1'b0 || out_grant !== '0 || out_random !== 8'd2 || out_owner !== '0) begin
            failures++;
            $display("FAIL single_hold: got valid=%b grant=%b random=%h owner=%0d want 0/0000/02/0",
                     out_valid, out_grant, out_random, out_owner);
        end
    endtask

    task automatic test_two_requesters();
        int n, w;
        logic [EXP_W-1:0] e;
        do_reset(8'h01);
        slot_min[0] = 8'sd0;  slot_max[0] = 8'sd9;
        slot_min[1] = -8'sd5; slot_max[1] = 8'sd5;
        apply_ranges();
        in_req = 4'b0011;
        predict(in_req, w);
        wait_valid(8, n);
        checks++; if (n !== 4) begin failures++; $display("FAIL two_latency0: got %0d want 4", n); end
        e = exp_q.pop_front();
        checks++; if (observed() !== e) begin failures++; $display("FAIL two_first: got %h want %h", observed(), e); end
        in_req[w] = 1'b0;
        predict(in_req, w);
        wait_valid(8, n);
        checks++; if (n !== 5) begin failures++; $display("FAIL two_latency1: got %0d want 5", n); end
        e = exp_q.pop_front();
        checks++; if (observed() !== e) begin failures++; $display("FAIL two_second: got %h want %h", observed(), e); end
        checks++;
        if (out_grant !== 4'b0010 || out_random !== 8'hFF) begin
            failures++;
            $display("FAIL two_second_value: got grant=%b random=%0d want 0010/-1", out_grant, $signed(out_random));
        end
        in_req = '0;
    endtask

    task automatic test_equal_inverted();
        int n, w;
        logic [EXP_W-1:0] e;
        do_reset(8'h01);
        slot_min[2] = 8'sd7; slot_max[2] = 8'sd7;
        slot_min[3] = 8'sd5; slot_max[3] = 8'sd3;
        apply_ranges();
        in_req = 4'b1100;
        for (int t = 0; t < 2; t++) begin
            predict(in_req, w);
            wait_valid(8, n);
            checks++; if (n !== (t == 0 ? 4 : 5)) begin failures++; $display("FAIL edge_latency%0d: got %0d", t, n); end
            e = exp_q.pop_front();
            checks++; if (observed() !== e) begin failures++; $display("FAIL edge_result%0d: got %h want %h", t, observed(), e); end
            in_req[w] = 1'b0;
        end
        // last strobe was slot 3 (min 5 > max 3)
        checks++;
        if (out_random !== 8'd5 || out_error !== 1'b1) begin
            failures++;
            $display("FAIL edge_inverted: got random=%0d error=%b want 5/1", $signed(out_random), out_error);
        end
    endtask

    task automatic test_all_held();
        int count;
        int per_req [NUM_REQ];
        int w;
        logic [EXP_W-1:0] e;
        do_reset(8'h37);
        for (int i = 0; i < NUM_REQ; i++) begin
            slot_min[i] = -8'sd20 * 8'(i);
            slot_max[i] = 8'sd10 * 8'(i + 1);
            per_req[i]  = 0;
        end
        apply_ranges();
        count  = 0;
        in_req = '1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge in_clock);
            @(negedge in_clock);
            if (out_valid === 1'b1) begin
                count++;
                strobes++;
                predict(in_req, w);
                per_req[w]++;
                e = exp_q.pop_front();
                checks++; if (observed() !== e) begin failures++; $display("FAIL held_result%0d: got %h want %h", count, observed(), e); end
            end else begin
                checks++; if (out_grant !== '0) begin failures++; $display("FAIL held_idle_grant c=%0d: got %b want 0", c, out_grant); end
            end
        end
        in_req = '0;
        checks++; if (count !== 8) begin failures++; $display("FAIL held_strobes: got %0d want 8", count); end
        for (int i = 0; i < NUM_REQ; i++) begin
            checks++; if (per_req[i] !== 2) begin failures++; $display("FAIL held_fair%0d: got %0d want 2", i, per_req[i]); end
        end
        repeat (6) @(negedge in_clock);
    endtask

    task automatic test_drop_after_arb();
        int n, w;
        logic [EXP_W-1:0] e;
        do_reset(8'h5A);
        slot_min[1] = -8'sd20; slot_max[1] = 8'sd20;
        apply_ranges();
        in_req = 4'b0010;
        predict(in_req, w);
        repeat (2) @(posedge in_clock);
        @(negedge in_clock);
        in_req = '0;
        slot_min[1] = 8'sd100; slot_max[1] = 8'sd100;
        apply_ranges();
        wait_valid(6, n);
        checks++; if (n !== 2) begin failures++; $display("FAIL drop_latency: got %0d want 2", n); end
        e = exp_q.pop_front();
        checks++; if (observed() !== e) begin failures++; $display("FAIL drop_result: got %h want %h", observed(), e); end
    endtask

    task automatic test_reset_mid();
        int n, w;
        int bad;
        logic [EXP_W-1:0] e;
        do_reset(8'h01);
        slot_min[0] = 8'sd0; slot_max[0] = 8'sd9;
        apply_ranges();
        in_req = 4'b0001;
        repeat (2) @(posedge in_clock);
        @(negedge in_clock);
        in_reset = 1'b1;
        in_seed  = 8'h01;
        in_req   = '0;
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge in_clock);
            if (out_valid !== 1'b0 || out_grant !== '0 || out_random !== 8'h0) bad++;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL abort_quiet: got %0d bad cycles want 0", bad); end
        in_reset = 1'b0;
        model_reset(8'h01);
        @(negedge in_clock);
        in_req = 4'b0001;
        predict(in_req, w);
        wait_valid(8, n);
        checks++; if (n !== 4) begin failures++; $display("FAIL abort_latency: got %0d want 4", n); end
        e = exp_q.pop_front();
        checks++; if (observed() !== e) begin failures++; $display("FAIL abort_result: got %h want %h", observed(), e); end
        checks++; if (out_random !== 8'd2) begin failures++; $display("FAIL abort_value: got %0d want 2", $signed(out_random)); end
        in_req = '0;
    endtask

    task automatic test_zero_seed();
        int n, w;
        do_reset(8'h00);
        slot_min[0] = 8'sd0; slot_max[0] = 8'sd9;
        apply_ranges();
        in_req = 4'b0001;
        predict(in_req, w);
        wait_valid(8, n);
        in_req = '0;
        checks++; if (out_random !== 8'd2 || n !== 4) begin failures++; $display("FAIL zero_seed: got random=%0d latency=%0d want 2/4", $signed(out_random), n); end
        void'(exp_q.pop_front());
        @(posedge in_clock);
        @(negedge in_clock);
`ifdef RANDOM_ARBITER_STATS_EN
        checks++; if (out_serviced_count !== 16'(strobes)) begin failures++; $display("FAIL zero_stats: got %0d want %0d", out_serviced_count, strobes); end
`endif
    endtask

    task automatic test_random();
        int n, w;
        bit first;
        logic [NUM_REQ-1:0] pend;
        logic signed [7:0] a, b;
        logic [EXP_W-1:0] e;
        do_reset(8'($urandom_range(1, 255)));
        for (int batch = 0; batch < 8; batch++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                a = 8'($urandom_range(0, 255));
                b = 8'($urandom_range(0, 255));
                // mostly well-formed ranges, some inverted ones
                if ((a > b) != ($urandom_range(0, 3) == 0)) begin
                    slot_min[i] = b; slot_max[i] = a;
                end else begin
                    slot_min[i] = a; slot_max[i] = b;
                end
            end
            apply_ranges();
            pend   = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
            in_req = pend;
            first  = 1'b1;
            while (pend != '0) begin
                predict(pend, w);
                wait_valid(8, n);
                checks++; if (n !== (first ? 4 : 5)) begin failures++; $display("FAIL rand_latency b%0d: got %0d want %0d", batch, n, first ? 4 : 5); end
                e = exp_q.pop_front();
                checks++; if (observed() !== e) begin failures++; $display("FAIL rand_result b%0d: got %h want %h", batch, observed(), e); end
                pend[w]   = 1'b0;
                in_req[w] = 1'b0;
                first     = 1'b0;
                if (n < 0) pend = '0;
            end
            in_req = '0;
            repeat (2) @(negedge in_clock);
        end
`ifdef RANDOM_ARBITER_STATS_EN
        checks++; if (out_serviced_count !== 16'(strobes)) begin failures++; $display("FAIL rand_stats: got %0d want %0d", out_serviced_count, strobes); end
`endif
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        for (int i = 0; i < NUM_REQ; i++) begin
            slot_min[i] = '0;
            slot_max[i] = '0;
        end
        test_reset();
        test_single();
        test_two_requesters();
        test_equal_inverted();
        test_all_held();
        test_drop_after_arb();
        test_reset_mid();
        test_zero_seed();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop in case a wait ever runs away.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/random_arbiter.md
RANDOM_ARBITER -- requirements
Module: random_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters sharing one random source (range 2..8).
REQ-002 The block SHALL have parameter IDX_W, default 2, giving the owner-index width (clog2(NUM_REQ)).
REQ-003 Port in_clock  input  1  system clock; all state updates on its rising edge.
REQ-004 Port in_reset  input  1  reset, asynchronous, active-high.
REQ-005 Port in_seed  input  8  LFSR seed, sampled only while in_reset=1.
REQ-006 Port in_req  input  NUM_REQ  per-requester request level, held high until the requester's grant pulse.
REQ-007 Port in_min  input  NUM_REQ*8  packed signed 8-bit range minimum per requester; slot i at bits [8i+7:8i].
REQ-008 Port in_max  input  NUM_REQ*8  packed signed 8-bit range maximum per requester, inclusive.
REQ-009 Port out_grant  output  NUM_REQ  one-hot grant, high for exactly one cycle together with out_valid.
REQ-010 Port out_valid  output  1  result-valid strobe.
REQ-011 Port out_random  output  8  signed result for the granted requester; held between strobes.
REQ-012 Port out_owner  output  IDX_W  index of the granted requester; held between strobes.
REQ-013 Port out_error  output  1  high with out_valid when the serviced range had min>max.

Function
REQ-014 The FSM SHALL have states IDLE, ARB, STEP, MAP, RESP; the sequence is IDLE->ARB->STEP->MAP->RESP->IDLE, each state lasting one cycle.
REQ-015 In IDLE the FSM SHALL move to ARB when any in_req bit is 1, else stay in IDLE.
REQ-016 In ARB the block SHALL select a winner round-robin, searching from (last_owner+1) mod NUM_REQ upward, and latch the winner's index, min and max.
REQ-017 The round-robin pointer after reset SHALL make requester 0 highest priority.
REQ-018 In STEP the LFSR SHALL advance once: next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}; the LFSR SHALL NOT advance in any other state.
REQ-019 In MAP the block SHALL compute span = max-min+1 in 9-bit signed arithmetic and result = min + (lfsr unsigned mod span), truncated to 8 bits.
REQ-020 When min==max the result SHALL be min; when min>max the result SHALL be min and out_error SHALL be 1 in RESP.
REQ-021 In RESP, out_valid=1 and out_grant=one-hot(owner) SHALL be asserted for one cycle, and out_random/out_owner SHALL update in the same cycle.
REQ-022 Latency from in_req sampled high in IDLE to out_valid SHALL be exactly 4 cycles; the sustained rate SHALL be one result per 5 cycles.
REQ-023 A request deasserted after ARB SHALL still be serviced to completion; in_req changes during STEP/MAP/RESP SHALL NOT affect the current transaction.
REQ-024 When all NUM_REQ bits are held high, each requester SHALL be granted once per NUM_REQ transactions.

Reset
REQ-025 While in_reset=1: state=IDLE, lfsr=in_seed (8'h01 if in_seed==0), pointer=0, all outputs 0.
REQ-026 Reset asserted mid-transaction SHALL abort it with no out_valid pulse.

Configuration
REQ-027 With macro RANDOM_ARBITER_STATS_EN defined, the block SHALL add output out_serviced_count (16 bits) counting RESP cycles, reset to 0, wrapping at 65535->0.
REQ-028 Without RANDOM_ARBITER_STATS_EN, the port and counter SHALL be absent and all other behaviour identical.

Structure
REQ-029 Package random_pkg SHALL hold RNG_WIDTH=8, the LFSR tap constant, the FSM state typedef and the zero-seed replacement constant 8'h01.
REQ-030 The LFSR register and step logic SHALL be sub-module lfsr8_core (ports: clock, reset, seed, step, value).

Verification
REQ-031 Seed 8'h01; in_req=4'b0001, range [0,9] -> out_valid 4 cycles later, out_grant=0001, out_random=2, out_owner=0.
REQ-032 Seed 8'h01; in_req=4'b0011 held; slot0 [0,9], slot1 [-5,5] -> first grant 0001 with value 2, then grant 0010 with value -1 (lfsr 8'h04 mod 11 - 5).
REQ-033 Slot2 min=max=7 -> out_random=7, out_error=0; slot3 min=5, max=3 -> out_random=5, out_error=1.
REQ-034 in_req=4'b1111 held for 40 cycles -> grants cycle 0,1,2,3,0,... with exactly 8 strobes, 2 per requester.
REQ-035 in_reset pulsed during STEP -> no out_valid, outputs 0, lfsr reloaded; the next request with seed 8'h01 returns the first-sequence value again.
REQ-036 in_seed=0 with reset -> lfsr loads 8'h01; with STATS_EN, out_serviced_count equals the strobe count.
